// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: two-requester round-robin front end that feeds whole frames to an SPI master.
//   params: DATA_W frame width, GAP_CYCLES idle cycles between frames, TIMEOUT wait limit for spi_done
//   in:     clk, rst (async, active-high), req0/req1, data0/data1, spi_done
//   out:    ack0/ack1 (completion pulses), err (timeout pulse with the ack), spi_start, spi_data,
//           busy (not IDLE), grant_id (current/last winner)
module spi_req_arbiter #(
  parameter int DATA_W     = 12,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_done,
  output logic              busy,
  output logic              grant_id
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          win;
  logic          fin;
  // On a tie the requester that did not win last time gets the bus.
  assign win  = (req0 & req1) ? ~grant_id : req1;
  // Frame ends either on spi_done or on the final permitted WAIT cycle.
  assign fin  = (state == S_WAIT) & (spi_done | (tcnt == T_LAST));
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      spi_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      grant_id  <= 1'b1;
      spi_data  <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
    end else begin
      // Registered pulses: start shows in the first WAIT cycle, ack/err in the cycle after WAIT.
      spi_start <= state == S_START;
      ack0      <= fin & ~grant_id;
      ack1      <= fin & grant_id;
      err       <= fin & ~spi_done;
      case (state)
        S_IDLE:
          if (req0 | req1) begin
            grant_id <= win;
            spi_data <= win ? data1 : data0;
            state    <= S_START;
          end
        S_START: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          if (fin) begin
            gcnt  <= '0;
            state <= GAP_CYCLES == 0 ? S_IDLE : S_GAP;
          end else
            tcnt <= tcnt + 1'b1;
        default:
          if (gcnt == G_LAST)
            state <= S_IDLE;
          else
            gcnt <= gcnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed checks of spi_req_arbiter across three parameter sets.
module tb_spi_req_arbiter;
  logic        clk = 1'b0;
  logic        rst, req0, req1, spi_done;
  logic [11:0] data0, data1;
  logic        ack0 [3];
  logic        ack1 [3];
  logic        err [3];
  logic        spi_start [3];
  logic        busy [3];
  logic        grant_id [3];
  logic [11:0] spi_data [3];
  int          tests = 0;
  int          fails = 0;
  int          starts0 = 0;
  int          snap;
  always #5 clk = ~clk;
  always @(negedge clk) if (spi_start[0]) starts0 <= starts0 + 1;
  spi_req_arbiter #(.DATA_W(12), .GAP_CYCLES(4), .TIMEOUT(64)) u0 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0[0]), .ack1(ack1[0]), .err(err[0]), .spi_start(spi_start[0]),
    .spi_data(spi_data[0]), .spi_done(spi_done), .busy(busy[0]), .grant_id(grant_id[0]));
  spi_req_arbiter #(.DATA_W(12), .GAP_CYCLES(4), .TIMEOUT(16)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0[1]), .ack1(ack1[1]), .err(err[1]), .spi_start(spi_start[1]),
    .spi_data(spi_data[1]), .spi_done(spi_done), .busy(busy[1]), .grant_id(grant_id[1]));
  spi_req_arbiter #(.DATA_W(12), .GAP_CYCLES(0), .TIMEOUT(16)) u2 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0[2]), .ack1(ack1[2]), .err(err[2]), .spi_start(spi_start[2]),
    .spi_data(spi_data[2]), .spi_done(spi_done), .busy(busy[2]), .grant_id(grant_id[2]));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; spi_done = 0; data0 = '0; data1 = '0;
    tick();
    tick();
    chk("rst_busy", busy[0], 0);
    chk("rst_start", spi_start[0], 0);
    chk("rst_ack0", ack0[0], 0);
    chk("rst_ack1", ack1[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_grant", grant_id[0], 1);
    chk("rst_data", spi_data[0], 0);
    rst = 1'b0;
    // single request, done 40 cycles after start
    snap = starts0;
    req0 = 1; data0 = 12'hA5C;
    tick();
    chk("s_busy", busy[0], 1);
    chk("s_start_early", spi_start[0], 0);
    chk("s_grant", grant_id[0], 0);
    chk("s_data", spi_data[0], 12'hA5C);
    data0 = 12'h000;
    tick();
    chk("s_start", spi_start[0], 1);
    repeat (39) tick();
    chk("s_hold_data", spi_data[0], 12'hA5C);
    chk("s_no_ack_yet", ack0[0], 0);
    spi_done = 1;
    tick();
    spi_done = 0; req0 = 0;
    chk("s_ack0", ack0[0], 1);
    chk("s_ack1", ack1[0], 0);
    chk("s_err", err[0], 0);
    chk("s_gap_busy", busy[0], 1);
    chk("s_one_start", starts0 - snap, 1);
    spi_done = 1;
    tick();
    spi_done = 0;
    chk("gap_ack_once", ack0[0], 0);
    chk("gap_busy1", busy[0], 1);
    tick();
    tick();
    chk("gap_busy3", busy[0], 1);
    chk("gap_stray_ack", ack0[0], 0);
    tick();
    chk("gap_end_idle", busy[0], 0);
    spi_done = 1;
    tick();
    spi_done = 0;
    chk("idle_stray_busy", busy[0], 0);
    chk("idle_stray_ack", ack0[0], 0);
    tick();
    chk("idle_stray_ack2", ack0[0] | ack1[0] | err[0], 0);
    // tie: both held high, round-robin 0,1,0,1
    do_reset();
    req0 = 1; req1 = 1; data0 = 12'h111; data1 = 12'h222;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_grant", grant_id[0], k % 2);
      chk("tie_data", spi_data[0], (k % 2) ? 12'h222 : 12'h111);
      tick();
      chk("tie_start", spi_start[0], 1);
      spi_done = 1;
      tick();
      spi_done = 0;
      chk("tie_ack_win", (k % 2) ? ack1[0] : ack0[0], 1);
      chk("tie_ack_other", (k % 2) ? ack0[0] : ack1[0], 0);
      repeat (4) tick();
    end
    req0 = 0; req1 = 0;
    // timeout on the TIMEOUT=16 instance
    do_reset();
    req0 = 1; data0 = 12'h3C3;
    tick();
    tick();
    chk("to_start", spi_start[1], 1);
    repeat (15) tick();
    chk("to_not_yet", ack0[1], 0);
    chk("to_busy", busy[1], 1);
    tick();
    req0 = 0;
    chk("to_ack0", ack0[1], 1);
    chk("to_err", err[1], 1);
    chk("to_gap", busy[1], 1);
    tick();
    chk("to_err_pulse", err[1], 0);
    repeat (3) tick();
    chk("to_idle", busy[1], 0);
    // reset asserted mid-frame
    do_reset();
    req0 = 1; data0 = 12'h5A5;
    tick();
    tick();
    tick();
    chk("rw_in_wait", busy[0], 1);
    rst = 1'b1;
    #1;
    chk("rw_busy", busy[0], 0);
    chk("rw_data", spi_data[0], 0);
    chk("rw_grant", grant_id[0], 1);
    chk("rw_start", spi_start[0], 0);
    tick();
    rst = 1'b0; req0 = 0; req1 = 1; data1 = 12'h6B6;
    chk("rw_no_ack", ack0[0] | ack1[0] | err[0], 0);
    tick();
    chk("rw_grant2", grant_id[0], 1);
    chk("rw_data2", spi_data[0], 12'h6B6);
    tick();
    chk("rw_start2", spi_start[0], 1);
    spi_done = 1;
    tick();
    spi_done = 0; req1 = 0;
    chk("rw_ack1", ack1[0], 1);
    chk("rw_ack0", ack0[0], 0);
    // GAP_CYCLES=0, req1 held: start recurs 2 cycles after each ack1
    do_reset();
    req1 = 1; data1 = 12'h7E7;
    tick();
    tick();
    chk("g0_start", spi_start[2], 1);
    for (int k = 0; k < 2; k++) begin
      spi_done = 1;
      tick();
      spi_done = 0;
      chk("g0_ack1", ack1[2], 1);
      chk("g0_idle", busy[2], 0);
      tick();
      chk("g0_start_gap", spi_start[2], 0);
      chk("g0_restart", busy[2], 1);
      tick();
      chk("g0_start_again", spi_start[2], 1);
      chk("g0_data", spi_data[2], 12'h7E7);
    end
    req1 = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter DATA_W, default 12, width of the SPI frame word.
REQ-002 Parameter GAP_CYCLES, default 4, idle cycles enforced between frames (0 allowed).
REQ-003 Parameter TIMEOUT, default 4096, max cycles waited for spi_done before abort (>=2).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 req0 / req1  in  1  request from requester 0 / 1; held high until its ack or err.
REQ-007 data0 / data1  in  DATA_W  word to send; held stable while the matching req is high.
REQ-008 ack0 / ack1  out  1  one-cycle pulse: frame for that requester completed.
REQ-009 err  out  1  one-cycle pulse, coincident with ack of the granted requester, when the frame timed out.
REQ-010 spi_start  out  1  one-cycle start pulse to the SPI master (its tx_enable).
REQ-011 spi_data  out  DATA_W  frame word to the SPI master.
REQ-012 spi_done  in  1  one-cycle pulse from the SPI master at end of frame (ss released).
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 grant_id  out  1  index of the current/last granted requester.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT, GAP.
REQ-016 IDLE: if req0 or req1 high, select winner, latch its data into spi_data, set grant_id, go START next cycle; else stay.
REQ-017 Arbitration SHALL be round-robin: if both requests are high, grant the requester not granted last; if one is high, grant it.
REQ-018 START: spi_start=1 for exactly this one cycle; go WAIT; clear timeout counter.
REQ-019 WAIT: on spi_done go GAP and pulse ack[grant_id] for one cycle in the first GAP cycle (or first IDLE cycle if GAP_CYCLES=0); err=0.
REQ-020 WAIT: timeout counter increments each cycle; when it reaches TIMEOUT-1 without spi_done, abort as REQ-019 but with err=1 alongside the ack.
REQ-021 spi_done seen outside WAIT SHALL be ignored.
REQ-022 spi_data SHALL stay constant from START through the end of WAIT; changes to data0/data1 after latching have no effect.
REQ-023 GAP: count GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 SHALL skip GAP (WAIT -> IDLE directly).
REQ-024 Requests are sampled only in IDLE; a request still high in the cycle after its ack SHALL be treated as a new request.
REQ-025 Minimum latency req -> spi_start SHALL be 2 cycles (req sampled in IDLE at edge N, spi_start high after edge N+1).
REQ-026 ack0 and ack1 SHALL never be high in the same cycle; at most one spi_start per frame.

Reset
REQ-027 While rst is high, state=IDLE and spi_start=0, ack0=ack1=0, err=0, busy=0, grant_id=1 (so requester 0 wins the first tie), spi_data=0, counters=0.
REQ-028 Reset mid-frame SHALL abandon the frame immediately with no ack or err pulse.
REQ-029 After rst falls, the first request is evaluated on the first rising edge with rst low.

Verification
REQ-030 Single request: req0=1, data0=12'hA5C, done 40 cycles after start -> one spi_start, spi_data=12'hA5C, ack0 pulse, err=0, busy low after 4 GAP cycles.
REQ-031 Tie: req0=req1=1 after reset -> grant order 0,1,0,1 across four frames; ack pulses never overlap.
REQ-032 Timeout: TIMEOUT=16, spi_done never asserted -> ack0 and err high together in the one cycle after 16 WAIT cycles, then GAP.
REQ-033 Stray done: spi_done pulsed in IDLE and GAP -> no state change, no ack.
REQ-034 Reset in WAIT: rst asserted mid-frame -> all outputs at reset values, no ack; next request after rst low served normally.
REQ-035 GAP_CYCLES=0, req1 held high -> back-to-back frames: spi_start recurs 2 cycles after each ack1.
